// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the data memory arbiter: FSM states and requester port ids.
package data_memory_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_RESP = 1'b1
    } arb_state_t;

    localparam logic PORT_LSU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/data_memory_arbiter_rr.sv
// Two-way round-robin grant: a lone requester always wins, on a tie the port
// that was not served last wins.
module rr_arbiter2
    import data_memory_arbiter_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_rr_last,
    output logic       o_grant_valid,
    output logic       o_grant
);

    always_comb begin
        o_grant_valid = |i_valid;
        if (i_valid == 2'b11) begin
            o_grant = ~i_rr_last;
        end else if (i_valid[1]) begin
            o_grant = PORT_DBG;
        end else begin
            o_grant = PORT_LSU;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-port data memory between the core LSU (port 0) and the debug
// loader (port 1); one access in flight, registered response with error flag.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic              r0_write,
    input  logic [DATA_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_rsp_valid,
    input  logic              r0_rsp_ready,
    output logic [DATA_W-1:0] r0_rsp_rdata,
    output logic              r0_rsp_err,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic              r1_write,
    input  logic [DATA_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_rsp_valid,
    input  logic              r1_rsp_ready,
    output logic [DATA_W-1:0] r1_rsp_rdata,
    output logic              r1_rsp_err,
    output logic              memory_read,
    output logic              memory_write,
    output logic [DATA_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data
);

    localparam logic [DATA_W-1:0] ADDR_LIMIT = DATA_W'(DEPTH_WORDS * 4);

    arb_state_t        r_state;
    logic              r_rr_last;
    logic              r_owner;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;

    logic              w_grant_valid;
    logic              w_grant;
    logic              w_accept;
    logic              w_write;
    logic [DATA_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_err;
    logic              w_owner_rsp_ready;

    rr_arbiter2 u_rr_arbiter2 (
        .i_valid      ({r1_valid, r0_valid}),
        .i_rr_last    (r_rr_last),
        .o_grant_valid(w_grant_valid),
        .o_grant      (w_grant)
    );

    // Reset gates the accept so nothing reaches memory while the arbiter is held in reset.
    assign w_accept          = (r_state == ARB_IDLE) && w_grant_valid && !reset;
    assign w_write           = (w_grant == PORT_DBG) ? r1_write : r0_write;
    assign w_addr            = (w_grant == PORT_DBG) ? r1_addr  : r0_addr;
    assign w_wdata           = (w_grant == PORT_DBG) ? r1_wdata : r0_wdata;
    assign w_err             = (w_addr[1:0] != 2'b00) || (w_addr >= ADDR_LIMIT);
    assign w_owner_rsp_ready = (r_owner == PORT_DBG) ? r1_rsp_ready : r0_rsp_ready;

    assign r0_ready     = w_accept && (w_grant == PORT_LSU);
    assign r1_ready     = w_accept && (w_grant == PORT_DBG);
    assign memory_read  = w_accept && !w_write && !w_err;
    assign memory_write = w_accept &&  w_write && !w_err;
    assign address      = w_accept ? w_addr  : '0;
    assign write_data   = w_accept ? w_wdata : '0;

    assign r0_rsp_valid = (r_state == ARB_RESP) && (r_owner == PORT_LSU);
    assign r1_rsp_valid = (r_state == ARB_RESP) && (r_owner == PORT_DBG);
    assign r0_rsp_rdata = r_rsp_rdata;
    assign r1_rsp_rdata = r_rsp_rdata;
    assign r0_rsp_err   = r_rsp_err;
    assign r1_rsp_err   = r_rsp_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ARB_IDLE;
            r_rr_last   <= PORT_DBG;
            r_owner     <= PORT_LSU;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_accept) begin
                        r_rr_last   <= w_grant;
                        r_owner     <= w_grant;
                        r_rsp_rdata <= (!w_write && !w_err) ? read_data : '0;
                        r_rsp_err   <= w_err;
                        r_state     <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    if (w_owner_rsp_ready) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Randomized self-checking bench for data_memory_arbiter against a transaction-level
// model (round-robin pointer plus a word array mirroring memory contents).
module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        r0_valid = 1'b0, r0_write = 1'b0, r0_rsp_ready = 1'b0;
    logic [31:0] r0_addr = '0, r0_wdata = '0;
    logic        r1_valid = 1'b0, r1_write = 1'b0, r1_rsp_ready = 1'b0;
    logic [31:0] r1_addr = '0, r1_wdata = '0;
    logic        r0_ready, r0_rsp_valid, r0_rsp_err;
    logic        r1_ready, r1_rsp_valid, r1_rsp_err;
    logic [31:0] r0_rsp_rdata, r1_rsp_rdata;
    logic        memory_read, memory_write;
    logic [31:0] address, write_data, read_data;

    logic        initMem = 1'b1;
    logic [31:0] devMem [0:1023];
    logic [31:0] refMem [0:1023];
    int          rrLast;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    data_memory_arbiter #(.DEPTH_WORDS(1024), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_write(r0_write),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_rsp_valid(r0_rsp_valid),
        .r0_rsp_ready(r0_rsp_ready), .r0_rsp_rdata(r0_rsp_rdata), .r0_rsp_err(r0_rsp_err),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_write(r1_write),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_rsp_valid(r1_rsp_valid),
        .r1_rsp_ready(r1_rsp_ready), .r1_rsp_rdata(r1_rsp_rdata), .r1_rsp_err(r1_rsp_err),
        .memory_read(memory_read), .memory_write(memory_write),
        .address(address), .write_data(write_data), .read_data(read_data)
    );

    function automatic logic [31:0] initWord(input int i);
        return 32'hA5A5_0000 | 32'(i);
    endfunction

    // Stand-in for data_memory: combinational read, write on the clock edge.
    assign read_data = devMem[address[11:2]];
    always @(posedge clk) begin
        if (initMem) begin
            for (int i = 0; i < 1024; i++) devMem[i] <= initWord(i);
        end else if (memory_write) begin
            devMem[address[11:2]] <= write_data;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic bit isErr(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd4096);
    endfunction

    // One complete access: present requests, check the grant and memory strobes,
    // check the response (optionally held off), then consume it.
    task automatic applyStimulus(input logic v0, input logic w0, input logic [31:0] a0,
                                 input logic [31:0] d0, input logic v1, input logic w1,
                                 input logic [31:0] a1, input logic [31:0] d1,
                                 input int hold, output int winner);
        int          eg;
        int          waited;
        logic        w;
        logic        err;
        logic [31:0] a, d, expRdata, rspData;
        logic        ownValid, othValid, rspErr;
        r0_valid = v0; r0_write = w0; r0_addr = a0; r0_wdata = d0;
        r1_valid = v1; r1_write = w1; r1_addr = a1; r1_wdata = d1;
        r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
        eg = (v0 && v1) ? ((rrLast == 1) ? 0 : 1) : (v1 ? 1 : 0);
        winner = -1;
        waited = 0;
        #1;
        while (!(r0_ready || r1_ready) && waited < 4) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!(r0_ready || r1_ready)) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
            r0_valid = 1'b0; r1_valid = 1'b0;
            return;
        end
        checkOutput("r0_ready", 32'(r0_ready), 32'(eg == 0));
        checkOutput("r1_ready", 32'(r1_ready), 32'(eg == 1));
        w = (eg == 1) ? w1 : w0;
        a = (eg == 1) ? a1 : a0;
        d = (eg == 1) ? d1 : d0;
        err = isErr(a);
        expRdata = (!w && !err) ? refMem[a[11:2]] : 32'd0;
        checkOutput("mem_read", 32'(memory_read), 32'(!w && !err));
        checkOutput("mem_write", 32'(memory_write), 32'(w && !err));
        if (!err) checkOutput("address", address, a);
        if (w && !err) checkOutput("write_data", write_data, d);
        @(posedge clk);
        rrLast = eg;
        if (w && !err) refMem[a[11:2]] = d;
        @(negedge clk);
        if (eg == 1) r1_valid = 1'b0; else r0_valid = 1'b0;
        for (int c = 0; c <= hold; c++) begin
            if (eg == 1) r0_rsp_ready = 1'($urandom_range(0, 1));
            else         r1_rsp_ready = 1'($urandom_range(0, 1));
            #1;
            ownValid = (eg == 1) ? r1_rsp_valid : r0_rsp_valid;
            othValid = (eg == 1) ? r0_rsp_valid : r1_rsp_valid;
            rspData  = (eg == 1) ? r1_rsp_rdata : r0_rsp_rdata;
            rspErr   = (eg == 1) ? r1_rsp_err   : r0_rsp_err;
            checkOutput("rsp_valid_owner", 32'(ownValid), 32'd1);
            checkOutput("rsp_valid_other", 32'(othValid), 32'd0);
            checkOutput("rsp_rdata", rspData, expRdata);
            checkOutput("rsp_err", 32'(rspErr), 32'(err));
            checkOutput("resp_readys", {30'd0, r1_ready, r0_ready}, 32'd0);
            checkOutput("resp_mem_idle", {30'd0, memory_write, memory_read}, 32'd0);
            checkOutput("resp_address", address, 32'd0);
            if (c < hold) @(negedge clk);
        end
        if (eg == 1) r1_rsp_ready = 1'b1; else r0_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
        #1;
        checkOutput("rsp_released", 32'((eg == 1) ? r1_rsp_valid : r0_rsp_valid), 32'd0);
        winner = eg;
    endtask

    function automatic logic [31:0] randAddr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return {20'd0, 6'($urandom_range(0, 63)), 6'd0} | 32'($urandom_range(1, 3));
        if (sel == 1) return 32'd4096 + {$urandom_range(0, 255), 2'b00};
        return {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    endfunction

    initial begin
        int   win;
        int   expGrant[4];
        logic pend[2];
        logic pw[2];
        logic [31:0] pa[2], pd[2];

        for (int i = 0; i < 1024; i++) refMem[i] = initWord(i);
        rrLast = 1;

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checkOutput("rst_readys", {30'd0, r1_ready, r0_ready}, 32'd0);
        checkOutput("rst_rsp_valid", {30'd0, r1_rsp_valid, r0_rsp_valid}, 32'd0);
        checkOutput("rst_mem", {30'd0, memory_write, memory_read}, 32'd0);
        reset = 1'b0; initMem = 1'b0;
        @(negedge clk); #1;
        checkOutput("idle_readys", {30'd0, r1_ready, r0_ready}, 32'd0);
        checkOutput("idle_rsp", {30'd0, r1_rsp_valid, r0_rsp_valid}, 32'd0);
        checkOutput("idle_mem", {30'd0, memory_write, memory_read}, 32'd0);
        checkOutput("idle_address", address, 32'd0);
        checkOutput("idle_rsp_rdata", r0_rsp_rdata, 32'd0);
        @(negedge clk);

        $display("[TB] store then load");
        applyStimulus(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, win);
        checkOutput("t1_grant", 32'(win), 32'd0);
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h10, 0, 0, win);
        checkOutput("t2_grant", 32'(win), 32'd1);
        checkOutput("t2_mem", devMem[4], 32'hDEADBEEF);

        $display("[TB] contention");
        expGrant = '{0, 1, 0, 1};
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 1, 32'h20 + 32'(4 * k), 32'h1000 + 32'(k), 1, 0, 32'h10, 0, 0, win);
            checkOutput("t3_grant", 32'(win), 32'(expGrant[k]));
        end

        $display("[TB] backpressure and errors");
        applyStimulus(1, 0, 32'h20, 0, 0, 0, 0, 0, 5, win);
        applyStimulus(1, 0, 32'h12, 0, 0, 0, 0, 0, 1, win);
        applyStimulus(0, 0, 0, 0, 1, 1, 32'h1000, 32'hBAD0BAD0, 0, win);
        checkOutput("t5_mem0", devMem[0], initWord(0));

        $display("[TB] reset during response");
        r1_valid = 1; r1_write = 0; r1_addr = 32'h10;
        @(posedge clk);
        @(negedge clk);
        r1_valid = 0; #1;
        checkOutput("t6_rsp_before", 32'(r1_rsp_valid), 32'd1);
        reset = 1'b1;
        r0_valid = 1; r0_write = 1; r0_addr = 32'h20; r0_wdata = 32'h12345678;
        #1;
        checkOutput("t6_rst_ready", 32'(r0_ready), 32'd0);
        checkOutput("t6_rst_write", 32'(memory_write), 32'd0);
        @(posedge clk);
        @(negedge clk); #1;
        checkOutput("t6_rsp_after", 32'(r1_rsp_valid), 32'd0);
        r0_valid = 0; reset = 1'b0;
        rrLast = 1;
        checkOutput("t6_mem", devMem[8], refMem[8]);
        applyStimulus(1, 0, 32'h20, 0, 1, 0, 32'h10, 0, 0, win);
        checkOutput("t6_grant", 32'(win), 32'd0);
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h10, 0, 0, win);

        $display("[TB] random traffic");
        pend = '{0, 0};
        for (int n = 0; n < 60; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) != 0) begin
                    pend[p] = 1; pw[p] = 1'($urandom_range(0, 1));
                    pa[p] = randAddr(); pd[p] = $urandom;
                end
            end
            if (!pend[0] && !pend[1]) begin
                pend[0] = 1; pw[0] = 0; pa[0] = randAddr(); pd[0] = 0;
            end
            applyStimulus(pend[0], pw[0], pa[0], pd[0], pend[1], pw[1], pa[1], pd[1],
                          $urandom_range(0, 3), win);
            if (win < 0) break;
            pend[win] = 0;
        end
        for (int i = 0; i < 16; i++) checkOutput("final_mem", devMem[i], refMem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
